// File: rtl/writeback_buffer.sv
// Writeback buffer: a small FIFO of pending register-file writes that drains
// one entry per free write-port cycle and offers a bypass lookup over every
// write that has not yet reached the register file.
module writeback_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_rd,
   input  logic [31:0]   in_data,
   input  logic          drain_en,
   input  logic          flush,
   output logic [4:0]    rd,
   output logic [31:0]   writedata,
   output logic          regwrite,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   output logic          hit_a,
   output logic          hit_b,
   output logic [31:0]   fwd_a,
   output logic [31:0]   fwd_b,
   output logic [AW:0]   count
);

   // Queue storage; entries outside [head, head+cnt) are stale and ignored.
   logic [4:0]    q_rd   [DEPTH];
   logic [31:0]   q_data [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   cnt;

   // Output (register-file write) stage.
   logic          vld_p1;
   logic [4:0]    rd_p1;
   logic [31:0]   data_p1;

   logic          accept;
   logic          store;
   logic          pop;
   logic [AW-1:0] slot;

   // Readiness depends only on registered occupancy, so a full buffer
   // refuses a request even when an entry drains on the same edge.
   assign in_ready = (cnt < (AW+1)'(DEPTH));
   assign accept   = in_valid & in_ready & ~flush;
   // Writes to r0 are architecturally void: consumed but never queued.
   assign store    = accept & (in_rd != 5'd0);
   assign pop      = (cnt != '0) & drain_en & ~flush;

   assign count     = cnt;
   assign regwrite  = vld_p1;
   assign rd        = rd_p1;
   assign writedata = data_p1;

   // Pointer and occupancy control; reset outranks flush, flush outranks traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (store) tail <= tail + AW'(1);
         if (pop)   head <= head + AW'(1);
         case ({store, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Queue storage write at the tail; contents are never cleared.
   always_ff @(posedge clk) begin
      if (store && !reset) begin
         q_rd[tail]   <= in_rd;
         q_data[tail] <= in_data;
      end
   end

   // Output stage: present the head entry for exactly one cycle per pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         rd_p1   <= 5'd0;
         data_p1 <= 32'd0;
      end else if (pop) begin
         vld_p1  <= 1'b1;
         rd_p1   <= q_rd[head];
         data_p1 <= q_data[head];
      end else begin
         vld_p1  <= 1'b0;
      end
   end

   // Bypass search, oldest first so the youngest match overrides: the output
   // stage is the oldest, then queue entries from head towards tail.
   always_comb begin
      hit_a = 1'b0;
      fwd_a = 32'd0;
      hit_b = 1'b0;
      fwd_b = 32'd0;
      slot  = '0;
      if (vld_p1 && (rd_p1 == rs)) begin
         hit_a = 1'b1;
         fwd_a = data_p1;
      end
      if (vld_p1 && (rd_p1 == rt)) begin
         hit_b = 1'b1;
         fwd_b = data_p1;
      end
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + AW'(k);
         if ((AW+1)'(k) < cnt) begin
            if (q_rd[slot] == rs) begin
               hit_a = 1'b1;
               fwd_a = q_data[slot];
            end
            if (q_rd[slot] == rt) begin
               hit_b = 1'b1;
               fwd_b = q_data[slot];
            end
         end
      end
      if (rs == 5'd0) begin
         hit_a = 1'b0;
         fwd_a = 32'd0;
      end
      if (rt == 5'd0) begin
         hit_b = 1'b0;
         fwd_b = 32'd0;
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_writeback_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    in_rd = 5'd0;
   logic [31:0]   in_data = 32'd0;
   logic          drain_en = 1'b0;
   logic          flush = 1'b0;
   logic [4:0]    rd;
   logic [31:0]   writedata;
   logic          regwrite;
   logic [4:0]    rs = 5'd0;
   logic [4:0]    rt = 5'd0;
   logic          hit_a;
   logic          hit_b;
   logic [31:0]   fwd_a;
   logic [31:0]   fwd_b;
   logic [AW:0]   count;

   writeback_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .drain_en(drain_en), .flush(flush),
      .rd(rd), .writedata(writedata), .regwrite(regwrite),
      .rs(rs), .rt(rt), .hit_a(hit_a), .hit_b(hit_b),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   // Reference model state: pending writes in arrival order plus the write port.
   ent_t        mq[$];
   logic        m_vld = 1'b0;
   logic [4:0]  m_rd = 5'd0;
   logic [31:0] m_wd = 32'd0;
   bit          m_acc = 1'b0;
   ent_t        wr_log[$];
   int          max_cnt = 0;

   typedef struct {
      logic        rst, iv;
      logic [4:0]  ird;
      logic [31:0] idat;
      logic        dr, fl;
      logic [4:0]  rs, rt;
      logic        e_rw;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
      logic [2:0]  e_cnt;
      logic        e_rdy, e_ha;
      logic [31:0] e_fa;
      logic        e_hb;
      logic [31:0] e_fb;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Youngest pending write to idx wins; the write port counts as the oldest.
   function automatic logic [32:0] m_look(input logic [4:0] idx);
      if (idx == 5'd0) return 33'd0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].r == idx) return {1'b1, mq[i].d};
      if (m_vld && m_rd == idx) return {1'b1, m_wd};
      return 33'd0;
   endfunction

   task automatic m_step();
      bit   rdy;
      ent_t e;
      m_acc = 1'b0;
      if (reset) begin
         mq.delete();
         m_vld = 1'b0;
         m_rd  = 5'd0;
         m_wd  = 32'd0;
      end else if (flush) begin
         mq.delete();
         m_vld = 1'b0;
      end else begin
         rdy = (mq.size() < DEPTH);
         if (mq.size() > 0 && drain_en) begin
            e = mq.pop_front();
            m_vld = 1'b1;
            m_rd  = e.r;
            m_wd  = e.d;
         end else begin
            m_vld = 1'b0;
         end
         if (in_valid && rdy) begin
            m_acc = 1'b1;
            if (in_rd != 5'd0) mq.push_back('{in_rd, in_data});
         end
      end
   endtask

   // One clock with model comparison before and after the edge.
   task automatic cyc();
      logic [32:0] la, lb;
      #1;
      la = m_look(rs);
      lb = m_look(rt);
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("hit_a", 32'(hit_a), 32'(la[32]));
      chk("fwd_a", fwd_a, la[31:0]);
      chk("hit_b", 32'(hit_b), 32'(lb[32]));
      chk("fwd_b", fwd_b, lb[31:0]);
      m_step();
      @(posedge clk);
      #1;
      chk("regwrite", 32'(regwrite), 32'(m_vld));
      chk("rd", 32'(rd), 32'(m_rd));
      chk("writedata", writedata, m_wd);
      chk("count", 32'(count), 32'(mq.size()));
      if (regwrite) wr_log.push_back('{rd, writedata});
      if (int'(count) > max_cnt) max_cnt = int'(count);
   endtask

   task automatic rst_cyc();
      reset = 1'b1; in_valid = 1'b0; drain_en = 1'b0; flush = 1'b0;
      rs = 5'd0; rt = 5'd0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_d[10];
      int n;

      // rst iv ird idat dr fl rs rt | rw rd wd cnt rdy ha fa hb fb
      tbl[0]  = '{1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,5'd0,5'd0, 1'b0,5'd0,32'h0,3'd0,1'b1,1'b0,32'h0,1'b0,32'h0};
      tbl[1]  = '{1'b0,1'b1,5'd5,32'hDEADBEEF,1'b1,1'b0,5'd5,5'd0, 1'b0,5'd0,32'h0,3'd1,1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0};
      tbl[2]  = '{1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,5'd5,5'd0, 1'b1,5'd5,32'hDEADBEEF,3'd0,1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0};
      tbl[3]  = '{1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,5'd5,5'd0, 1'b0,5'd5,32'hDEADBEEF,3'd0,1'b1,1'b0,32'h0,1'b0,32'h0};
      tbl[4]  = '{1'b0,1'b1,5'd0,32'h1,1'b1,1'b0,5'd0,5'd0, 1'b0,5'd5,32'hDEADBEEF,3'd0,1'b1,1'b0,32'h0,1'b0,32'h0};
      tbl[5]  = '{1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,5'd0,5'd0, 1'b0,5'd5,32'hDEADBEEF,3'd0,1'b1,1'b0,32'h0,1'b0,32'h0};
      tbl[6]  = '{1'b0,1'b1,5'd7,32'h11,1'b0,1'b0,5'd7,5'd8, 1'b0,5'd5,32'hDEADBEEF,3'd1,1'b1,1'b1,32'h11,1'b0,32'h0};
      tbl[7]  = '{1'b0,1'b1,5'd7,32'h22,1'b0,1'b0,5'd7,5'd8, 1'b0,5'd5,32'hDEADBEEF,3'd2,1'b1,1'b1,32'h22,1'b0,32'h0};
      tbl[8]  = '{1'b0,1'b0,5'd0,32'h0,1'b0,1'b0,5'd7,5'd7, 1'b0,5'd5,32'hDEADBEEF,3'd2,1'b1,1'b1,32'h22,1'b1,32'h22};
      tbl[9]  = '{1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,5'd7,5'd8, 1'b1,5'd7,32'h11,3'd1,1'b1,1'b1,32'h22,1'b0,32'h0};
      tbl[10] = '{1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,5'd7,5'd8, 1'b1,5'd7,32'h22,3'd0,1'b1,1'b1,32'h22,1'b0,32'h0};
      tbl[11] = '{1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,5'd7,5'd8, 1'b0,5'd7,32'h22,3'd0,1'b1,1'b0,32'h0,1'b0,32'h0};

      for (int i = 0; i < 12; i++) begin
         reset = tbl[i].rst; in_valid = tbl[i].iv; in_rd = tbl[i].ird;
         in_data = tbl[i].idat; drain_en = tbl[i].dr; flush = tbl[i].fl;
         rs = tbl[i].rs; rt = tbl[i].rt;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_regwrite", i), 32'(regwrite), 32'(tbl[i].e_rw));
         chk($sformatf("v%0d_rd", i), 32'(rd), 32'(tbl[i].e_rd));
         chk($sformatf("v%0d_writedata", i), writedata, tbl[i].e_wd);
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_hit_a", i), 32'(hit_a), 32'(tbl[i].e_ha));
         chk($sformatf("v%0d_fwd_a", i), fwd_a, tbl[i].e_fa);
         chk($sformatf("v%0d_hit_b", i), 32'(hit_b), 32'(tbl[i].e_hb));
         chk($sformatf("v%0d_fwd_b", i), fwd_b, tbl[i].e_fb);
      end

      // Fill to capacity with the port blocked, then drain in order.
      rst_cyc();
      wr_log.delete();
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
         cyc();
      end
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_ready", 32'(in_ready), 32'd0);
      in_rd = 5'd5; in_data = 32'h105;
      cyc();
      chk("held_count", 32'(count), 32'd4);
      drain_en = 1'b1;
      for (int k = 0; k < 20 && wr_log.size() < 5; k++) begin
         cyc();
         if (m_acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      cyc();
      cyc();
      chk("bp_nwrites", 32'(wr_log.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("bp_order%0d", i),
             (i < wr_log.size()) ? 32'(wr_log[i].r) : 32'hFFFF_FFFF, 32'(i + 1));

      // Flush with a simultaneous request, then reset mid-operation.
      rst_cyc();
      drain_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_rd = 5'(11 + i); in_data = 32'hA0 + 32'(i);
         cyc();
      end
      chk("pre_flush_count", 32'(count), 32'd3);
      flush = 1'b1; in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h99;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_regwrite", 32'(regwrite), 32'd0);
      rs = 5'd11; rt = 5'd9;
      #1;
      chk("flush_hit_a", 32'(hit_a), 32'd0);
      chk("flush_hit_b", 32'(hit_b), 32'd0);
      rs = 5'd0; rt = 5'd0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_rd = 5'(20 + i); in_data = 32'hB0 + 32'(i);
         cyc();
      end
      in_valid = 1'b0; drain_en = 1'b1;
      cyc();
      chk("refill_count", 32'(count), 32'd2);
      chk("refill_rd", 32'(rd), 32'd20);
      reset = 1'b1; in_valid = 1'b1; in_rd = 5'd3; in_data = 32'h33;
      cyc();
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_regwrite", 32'(regwrite), 32'd0);
      cyc();
      chk("post_rst_regwrite", 32'(regwrite), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);

      // Ten back-to-back requests with the port free: pointers must wrap.
      rst_cyc();
      wr_log.delete();
      max_cnt = 0;
      drain_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_d[i] = $urandom;
         in_valid = 1'b1; in_rd = 5'(i + 1); in_data = exp_d[i];
         n = 0;
         do begin
            cyc();
            n++;
         end while (!m_acc && n < 8);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 20 && wr_log.size() < 10; k++) cyc();
      chk("wrap_nwrites", 32'(wr_log.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("wrap_rd%0d", i),
             (i < wr_log.size()) ? 32'(wr_log[i].r) : 32'hFFFF_FFFF, 32'(i + 1));
         chk($sformatf("wrap_data%0d", i),
             (i < wr_log.size()) ? wr_log[i].d : ~exp_d[i], exp_d[i]);
      end
      chk("wrap_max_count_ok", 32'(max_cnt <= DEPTH), 32'd1);

      // Randomized traffic against the reference model.
      rst_cyc();
      for (int c = 0; c < 1500; c++) begin
         reset    = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         in_rd    = 5'($urandom_range(0, 7));
         in_data  = $urandom;
         drain_en = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 3) == 0);
         rs       = 5'($urandom_range(0, 7));
         rt       = 5'($urandom_range(0, 7));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
